uart_debug_loader: RTL
======================

// Module: uart_debug_loader
// PURPOSE
//   Command controller sitting after the UART receiver in the MIPS debug path.
//   Consumes received bytes (rx_done_tick/data), decodes single-byte commands,
//   assembles 32-bit instruction words and writes them into instruction memory.
//   Drives CPU run/step/halt control and returns ACK/NAK bytes via the UART transmitter.
// PARAMETERS
//   N_BITS_DATA    8      UART byte width
//   N_BITS_WORD    32     instruction word width (multiple of N_BITS_DATA)
//   N_BITS_ADDR    10     instruction memory word-address width
//   TIMEOUT_CYCLES 1000000  max idle clocks between bytes inside a load before abort
// PORTS
//   clock        in   1            system clock, all state on posedge
//   reset        in   1            asynchronous, active-low reset
//   rx_done_tick in   1            one-cycle pulse: rx_data valid
//   rx_data      in   N_BITS_DATA  received byte
//   tx_busy      in   1            transmitter busy; tx_start ignored while high
//   tx_start     out  1            one-cycle pulse: send tx_data
//   tx_data      out  N_BITS_DATA  byte to send (held until next tx_start)
//   imem_wr_en   out  1            one-cycle write strobe
//   imem_addr    out  N_BITS_ADDR  word address of write
//   imem_wr_data out  N_BITS_WORD  assembled word
//   cpu_run      out  1            level: CPU free-running
//   cpu_step     out  1            one-cycle pulse: execute one instruction
//   load_busy    out  1            high in any state other than IDLE
//   err_pulse    out  1            one-cycle pulse: unknown cmd, timeout or checksum fail
// BEHAVIOUR
//   Reset (async, reset==0): all outputs 0, FSM->IDLE, addr/byte/word counters 0.
//   FSM states: IDLE, LEN, DATA, WRITE, ACK.
//   IDLE, on rx_done_tick decode rx_data:
//     'L'(0x4C): cpu_run<=0 same edge; ->LEN.  'R'(0x52): cpu_run<=1.
//     'S'(0x53): cpu_step pulse next cycle, only if cpu_run==0 (else ignored).
//     'H'(0x48): cpu_run<=0.  Other: err_pulse, stay IDLE.
//   LEN: next byte = word count N; N==0 means 256 words. addr<=0; ->DATA.
//   DATA: bytes packed LSB-first: byte k of word -> bits [8k+7:8k]. After byte
//     N_BITS_WORD/8 -> WRITE.
//   WRITE: one cycle; imem_wr_en=1 with addr/data (write 1 clk after last byte).
//     addr+1 (wraps mod 2^N_BITS_ADDR); words_left-1; ->DATA or, if 0, ->ACK(0x06).
//   ACK: wait tx_busy==0, then pulse tx_start with tx_data; ->IDLE.
//     rx bytes arriving in WRITE or ACK are dropped silently.
//   Timeout: in LEN/DATA, idle counter reset on each rx_done_tick; reaching
//     TIMEOUT_CYCLES -> err_pulse, partial word discarded, ->ACK with 0x15 (NAK).
//     Words already written stay written.
//   rx_done_tick same cycle as timeout expiry: byte wins, counter clears.
//   Reset mid-load: immediate abort, no further writes, nothing transmitted.
// CONFIGURATION
//   UART_LOADER_CHECKSUM_EN defined: after last WRITE, one extra byte expected
//     = XOR of all payload bytes (not 'L', not N). Match -> ACK 0x06;
//     mismatch -> err_pulse + NAK 0x15. Checksum byte subject to timeout.
//   Undefined: no checksum byte; ACK 0x06 right after last WRITE.
// TESTING
//   'L',0x01,0x78,0x56,0x34,0x12 -> one imem_wr_en: addr 0, data 0x12345678; tx 0x06.
//   'L',0x02 + 8 bytes -> writes addr 0,1 in order; cpu_run forced 0 if previously 1.
//   'R' then 'S' -> cpu_run=1, no cpu_step; 'H','S' -> cpu_run=0, one cpu_step pulse.
//   'L',0x01,0xAA then silence TIMEOUT_CYCLES -> err_pulse, no write, tx 0x15.
//   tx_busy held 1 at ACK -> tx_start delayed until tx_busy falls; 0x7A -> err_pulse only.
//   CHECKSUM_EN: 'L',0x01,01,02,04,08,chk 0x0F -> 0x06; chk 0x00 -> err_pulse, 0x15.

Source files
------------

// File: rtl/uart_debug_loader_if.sv
// rtl/uart_debug_loader_if.sv - UART rx/tx handshake and instruction-memory write bus for the debug loader
//
// Signals:
//   rx_done_tick / rx_data    byte strobe and payload from the UART receiver
//   tx_busy                   UART transmitter busy
//   tx_start / tx_data        byte send request to the UART transmitter
//   imem_wr_en / imem_addr / imem_wr_data   instruction memory write port
// Modports:
//   master  the loader (consumes rx, drives tx and imem)
//   slave   the surrounding UART / memory environment
interface uart_debug_loader_if #(
   parameter int N_BITS_DATA = 8,
   parameter int N_BITS_WORD = 32,
   parameter int N_BITS_ADDR = 10
);
   logic                   rx_done_tick;
   logic [N_BITS_DATA-1:0] rx_data;
   logic                   tx_busy;
   logic                   tx_start;
   logic [N_BITS_DATA-1:0] tx_data;
   logic                   imem_wr_en;
   logic [N_BITS_ADDR-1:0] imem_addr;
   logic [N_BITS_WORD-1:0] imem_wr_data;

   modport master (
      input  rx_done_tick, rx_data, tx_busy,
      output tx_start, tx_data, imem_wr_en, imem_addr, imem_wr_data
   );

   modport slave (
      output rx_done_tick, rx_data, tx_busy,
      input  tx_start, tx_data, imem_wr_en, imem_addr, imem_wr_data
   );
endinterface

// File: rtl/uart_debug_loader.sv
// rtl/uart_debug_loader.sv - UART debug command decoder and instruction-memory loader
//
// Decodes single-byte commands ('L' load, 'R' run, 'S' step, 'H' halt), assembles
// little-endian instruction words, writes them to instruction memory and answers
// each load with ACK (0x06) or NAK (0x15).
// Optional feature macro: UART_LOADER_CHECKSUM_EN (trailing XOR checksum byte per load).
//
// Ports:
//   clock, reset   system clock, asynchronous active-low reset
//   bus            uart_debug_loader_if.master (rx bytes, tx bytes, imem write)
//   cpu_run        level: CPU free-running
//   cpu_step       one-cycle pulse: execute one instruction
//   load_busy      high whenever the loader FSM is not idle
//   err_pulse      one-cycle pulse: unknown command, timeout or checksum mismatch
module uart_debug_loader #(
   parameter int N_BITS_DATA    = 8,
   parameter int N_BITS_WORD    = 32,
   parameter int N_BITS_ADDR    = 10,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                    clock,
   input  logic                    reset,
   uart_debug_loader_if.master     bus,
   output logic                    cpu_run,
   output logic                    cpu_step,
   output logic                    load_busy,
   output logic                    err_pulse
);
   localparam int BYTES = N_BITS_WORD / N_BITS_DATA;
   localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam int WL    = N_BITS_DATA + 1;   // word count up to 2^N_BITS_DATA

   localparam logic [N_BITS_DATA-1:0] CMD_L = N_BITS_DATA'(8'h4C);
   localparam logic [N_BITS_DATA-1:0] CMD_R = N_BITS_DATA'(8'h52);
   localparam logic [N_BITS_DATA-1:0] CMD_S = N_BITS_DATA'(8'h53);
   localparam logic [N_BITS_DATA-1:0] CMD_H = N_BITS_DATA'(8'h48);
   localparam logic [N_BITS_DATA-1:0] ACK_B = N_BITS_DATA'(8'h06);
   localparam logic [N_BITS_DATA-1:0] NAK_B = N_BITS_DATA'(8'h15);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN, S_DATA, S_WRITE, S_ACK, S_CHK
   } state_t;

   state_t                 state_q, state_d;
   logic [N_BITS_ADDR-1:0] addr_q, addr_d;
   logic [WL-1:0]          words_q, words_d;
   logic [BCW-1:0]         byte_q, byte_d;
   logic [N_BITS_WORD-1:0] word_q, word_d;
   logic [TW-1:0]          idle_q, idle_d;
   logic [N_BITS_DATA-1:0] tx_data_q, tx_data_d;
   logic                   run_q, run_d;
   logic                   step_q, step_d;
   logic                   err_q, err_d;
   logic                   timeout;
`ifdef UART_LOADER_CHECKSUM_EN
   logic [N_BITS_DATA-1:0] chk_q, chk_d;
`endif

   // A byte arriving on the expiry cycle wins over the timeout.
   assign timeout = (idle_q == TW'(TIMEOUT_CYCLES - 1)) && !bus.rx_done_tick;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         words_q   <= '0;
         byte_q    <= '0;
         word_q    <= '0;
         idle_q    <= '0;
         tx_data_q <= '0;
         run_q     <= 1'b0;
         step_q    <= 1'b0;
         err_q     <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
         chk_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         words_q   <= words_d;
         byte_q    <= byte_d;
         word_q    <= word_d;
         idle_q    <= idle_d;
         tx_data_q <= tx_data_d;
         run_q     <= run_d;
         step_q    <= step_d;
         err_q     <= err_d;
`ifdef UART_LOADER_CHECKSUM_EN
         chk_q     <= chk_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      words_d   = words_q;
      byte_d    = byte_q;
      word_d    = word_q;
      idle_d    = '0;
      tx_data_d = tx_data_q;
      run_d     = run_q;
      step_d    = 1'b0;
      err_d     = 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      chk_d     = chk_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.rx_done_tick) begin
               case (bus.rx_data)
                  CMD_L: begin
                     run_d   = 1'b0;
                     state_d = S_LEN;
                  end
                  CMD_R:   run_d  = 1'b1;
                  CMD_S:   step_d = !run_q;
                  CMD_H:   run_d  = 1'b0;
                  default: err_d  = 1'b1;
               endcase
            end
         end
         S_LEN: begin
            if (bus.rx_done_tick) begin
               words_d = (bus.rx_data == '0) ? WL'(1 << N_BITS_DATA) : WL'(bus.rx_data);
               addr_d  = '0;
               byte_d  = '0;
`ifdef UART_LOADER_CHECKSUM_EN
               chk_d   = '0;
`endif
               state_d = S_DATA;
            end else if (timeout) begin
               err_d     = 1'b1;
               tx_data_d = NAK_B;
               state_d   = S_ACK;
            end else begin
               idle_d = idle_q + TW'(1);
            end
         end
         S_DATA: begin
            if (bus.rx_done_tick) begin
               // Shift in from the top so byte 0 ends up in the lowest lane.
               word_d = {bus.rx_data, word_q[N_BITS_WORD-1:N_BITS_DATA]};
`ifdef UART_LOADER_CHECKSUM_EN
               chk_d  = chk_q ^ bus.rx_data;
`endif
               if (byte_q == BCW'(BYTES - 1)) begin
                  byte_d  = '0;
                  state_d = S_WRITE;
               end else begin
                  byte_d = byte_q + BCW'(1);
               end
            end else if (timeout) begin
               err_d     = 1'b1;
               byte_d    = '0;
               tx_data_d = NAK_B;
               state_d   = S_ACK;
            end else begin
               idle_d = idle_q + TW'(1);
            end
         end
         S_WRITE: begin
            addr_d  = addr_q + N_BITS_ADDR'(1);
            words_d = words_q - WL'(1);
            if (words_q == WL'(1)) begin
`ifdef UART_LOADER_CHECKSUM_EN
               state_d = S_CHK;
`else
               tx_data_d = ACK_B;
               state_d   = S_ACK;
`endif
            end else begin
               state_d = S_DATA;
            end
         end
         S_CHK: begin
`ifdef UART_LOADER_CHECKSUM_EN
            if (bus.rx_done_tick) begin
               if (bus.rx_data == chk_q) begin
                  tx_data_d = ACK_B;
               end else begin
                  err_d     = 1'b1;
                  tx_data_d = NAK_B;
               end
               state_d = S_ACK;
            end else if (timeout) begin
               err_d     = 1'b1;
               tx_data_d = NAK_B;
               state_d   = S_ACK;
            end else begin
               idle_d = idle_q + TW'(1);
            end
`else
            state_d = S_IDLE;
`endif
         end
         S_ACK: begin
            if (!bus.tx_busy) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.imem_wr_en   = (state_q == S_WRITE);
   assign bus.imem_addr    = addr_q;
   assign bus.imem_wr_data = word_q;
   assign bus.tx_start     = (state_q == S_ACK) && !bus.tx_busy;
   assign bus.tx_data      = tx_data_q;
   assign cpu_run          = run_q;
   assign cpu_step         = step_q;
   assign err_pulse        = err_q;
   assign load_busy        = (state_q != S_IDLE);
endmodule
